regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file (RegWrite/WriteRegister/WriteData) between two independent requesters, A and B. Each requester uses a valid/ready handshake.
- After reset, the block first runs a scrub sequence that writes zero to every register except register 0.
- It then arbitrates round-robin between the two requesters.
- Each requester has a one-entry hold buffer, so a requester can hand off a write while the other side's write is being issued.

---
 rtl/regfile_write_arbiter.sv | 179 +++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between two valid/ready requesters.
// A post-reset scrub zeroes registers 1..NUM_REGS-1, then A and B are served round-robin.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  ReqValidA,
  output logic                  ReqReadyA,
  input  logic [ADDR_WIDTH-1:0] ReqAddrA,
  input  logic [DATA_WIDTH-1:0] ReqDataA,
  input  logic                  ReqValidB,
  output logic                  ReqReadyB,
  input  logic [ADDR_WIDTH-1:0] ReqAddrB,
  input  logic [DATA_WIDTH-1:0] ReqDataB,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  GrantA,
  output logic                  GrantB,
  output logic                  InitDone
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

  state_t                  state_r, state_next_s;
  logic [ADDR_WIDTH-1:0]   cnt_r, cnt_next_s;
  logic                    ptr_r, ptr_next_s;          // 0 = A has priority, 1 = B
  logic                    hold_valid_a_r, hold_valid_a_next_s;
  logic                    hold_valid_b_r, hold_valid_b_next_s;
  logic [ADDR_WIDTH-1:0]   hold_addr_a_r, hold_addr_a_next_s;
  logic [ADDR_WIDTH-1:0]   hold_addr_b_r, hold_addr_b_next_s;
  logic [DATA_WIDTH-1:0]   hold_data_a_r, hold_data_a_next_s;
  logic [DATA_WIDTH-1:0]   hold_data_b_r, hold_data_b_next_s;
  logic                    regwrite_r, regwrite_next_s;
  logic [ADDR_WIDTH-1:0]   wreg_r, wreg_next_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_next_s;
  logic                    grant_a_r, grant_a_next_s;
  logic                    grant_b_r, grant_b_next_s;
  logic                    done_r, done_next_s;

  logic run_s, grant_a_s, grant_b_s, accept_a_s, accept_b_s;

  // The pointer only breaks ties; a lone valid hold always wins.
  assign run_s      = (state_r == ST_RUN);
  assign grant_a_s  = run_s & hold_valid_a_r & (~hold_valid_b_r | ~ptr_r);
  assign grant_b_s  = run_s & hold_valid_b_r & (~hold_valid_a_r |  ptr_r);
  assign ReqReadyA  = run_s & (~hold_valid_a_r | grant_a_s);
  assign ReqReadyB  = run_s & (~hold_valid_b_r | grant_b_s);
  assign accept_a_s = ReqValidA & ReqReadyA;
  assign accept_b_s = ReqValidB & ReqReadyB;

  assign RegWrite      = regwrite_r;
  assign WriteRegister = wreg_r;
  assign WriteData     = wdata_r;
  assign GrantA        = grant_a_r;
  assign GrantB        = grant_b_r;
  assign InitDone      = done_r;

  // Next-state, hold-buffer and write-port computation for scrub and run phases.
  always_comb begin
    state_next_s        = state_r;
    cnt_next_s          = cnt_r;
    ptr_next_s          = ptr_r;
    hold_valid_a_next_s = hold_valid_a_r;
    hold_valid_b_next_s = hold_valid_b_r;
    hold_addr_a_next_s  = hold_addr_a_r;
    hold_addr_b_next_s  = hold_addr_b_r;
    hold_data_a_next_s  = hold_data_a_r;
    hold_data_b_next_s  = hold_data_b_r;
    regwrite_next_s     = 1'b0;
    wreg_next_s         = wreg_r;
    wdata_next_s        = wdata_r;
    grant_a_next_s      = 1'b0;
    grant_b_next_s      = 1'b0;
    done_next_s         = done_r;
    case (state_r)
      ST_INIT: begin
        regwrite_next_s = 1'b1;
        wreg_next_s     = cnt_r;
        wdata_next_s    = ZERO_DATA;
        cnt_next_s      = cnt_r + ONE_ADDR;
        if (cnt_r == LAST_ADDR) begin
          state_next_s = ST_RUN;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN: begin
        // Register 0 is granted like any other address but never written.
        if (grant_a_s) begin
          regwrite_next_s = (hold_addr_a_r != ZERO_ADDR);
          wreg_next_s     = hold_addr_a_r;
          wdata_next_s    = hold_data_a_r;
          grant_a_next_s  = 1'b1;
        end else if (grant_b_s) begin
          regwrite_next_s = (hold_addr_b_r != ZERO_ADDR);
          wreg_next_s     = hold_addr_b_r;
          wdata_next_s    = hold_data_b_r;
          grant_b_next_s  = 1'b1;
        end else begin
          regwrite_next_s = 1'b0;
        end
        if (hold_valid_a_r & hold_valid_b_r) begin
          ptr_next_s = grant_a_s;
        end else begin
          ptr_next_s = ptr_r;
        end
        if (accept_a_s) begin
          hold_valid_a_next_s = 1'b1;
          hold_addr_a_next_s  = ReqAddrA;
          hold_data_a_next_s  = ReqDataA;
        end else if (grant_a_s) begin
          hold_valid_a_next_s = 1'b0;
        end else begin
          hold_valid_a_next_s = hold_valid_a_r;
        end
        if (accept_b_s) begin
          hold_valid_b_next_s = 1'b1;
          hold_addr_b_next_s  = ReqAddrB;
          hold_data_b_next_s  = ReqDataB;
        end else if (grant_b_s) begin
          hold_valid_b_next_s = 1'b0;
        end else begin
          hold_valid_b_next_s = hold_valid_b_r;
        end
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase
  end

  // State and output registers; reset restarts the scrub and drops held requests.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r        <= ST_INIT;
      cnt_r          <= ONE_ADDR;
      ptr_r          <= 1'b0;
      hold_valid_a_r <= 1'b0;
      hold_valid_b_r <= 1'b0;
      hold_addr_a_r  <= ZERO_ADDR;
      hold_addr_b_r  <= ZERO_ADDR;
      hold_data_a_r  <= ZERO_DATA;
      hold_data_b_r  <= ZERO_DATA;
      regwrite_r     <= 1'b0;
      wreg_r         <= ZERO_ADDR;
      wdata_r        <= ZERO_DATA;
      grant_a_r      <= 1'b0;
      grant_b_r      <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      cnt_r          <= cnt_next_s;
      ptr_r          <= ptr_next_s;
      hold_valid_a_r <= hold_valid_a_next_s;
      hold_valid_b_r <= hold_valid_b_next_s;
      hold_addr_a_r  <= hold_addr_a_next_s;
      hold_addr_b_r  <= hold_addr_b_next_s;
      hold_data_a_r  <= hold_data_a_next_s;
      hold_data_b_r  <= hold_data_b_next_s;
      regwrite_r     <= regwrite_next_s;
      wreg_r         <= wreg_next_s;
      wdata_r        <= wdata_next_s;
      grant_a_r      <= grant_a_next_s;
      grant_b_r      <= grant_b_next_s;
      done_r         <= done_next_s;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, scrub and mid-run reset
// sequences, and random traffic against a queue-based model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int NR = 32;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        ReqValidA, ReqValidB;
  logic        ReqReadyA, ReqReadyB;
  logic [4:0]  ReqAddrA, ReqAddrB;
  logic [31:0] ReqDataA, ReqDataB;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        GrantA, GrantB, InitDone;

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(NR)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReqValidA(ReqValidA), .ReqReadyA(ReqReadyA), .ReqAddrA(ReqAddrA), .ReqDataA(ReqDataA),
    .ReqValidB(ReqValidB), .ReqReadyB(ReqReadyB), .ReqAddrB(ReqAddrB), .ReqDataB(ReqDataB),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .GrantA(GrantA), .GrantB(GrantB), .InitDone(InitDone)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;

  // register file fed by the DUT write port, plus stale-write watch after mid-run reset
  logic [31:0] rf [NR];
  logic [31:0] exp_rf [NR];
  bit          watch = 1'b0;
  int          stale_cnt = 0;

  always @(posedge Clk) begin
    if (RegWrite) begin
      rf[WriteRegister] <= WriteData;
      if (watch && (WriteData == 32'h5A5A0004 || WriteData == 32'h5A5A0007 ||
                    WriteData == 32'h5A5A000C))
        stale_cnt <= stale_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // reference model: one-deep queues per requester, tie pointer, scrub counter
  typedef struct { logic [4:0] a; logic [31:0] d; } hold_t;
  hold_t hq_a[$], hq_b[$];
  bit    m_run, m_ptr;
  int    m_cnt;
  logic        e_rw, e_ga, e_gb, e_done;
  logic [4:0]  e_wr;
  logic [31:0] e_wd;

  task automatic model_reset();
    hq_a.delete(); hq_b.delete();
    m_run = 1'b0; m_ptr = 1'b0; m_cnt = 1;
    e_rw = 1'b0; e_wr = 5'd0; e_wd = 32'd0; e_ga = 1'b0; e_gb = 1'b0; e_done = 1'b0;
  endtask

  task automatic issue(input hold_t h, input bit from_a);
    e_rw = (h.a != 5'd0);
    e_wr = h.a;
    e_wd = h.d;
    e_ga = from_a;
    e_gb = !from_a;
    if (h.a != 5'd0) exp_rf[h.a] = h.d;
  endtask

  task automatic chk_outputs();
    chk("regwrite", 32'(RegWrite), 32'(e_rw));
    chk("writereg", 32'(WriteRegister), 32'(e_wr));
    chk("writedata", WriteData, e_wd);
    chk("grants", 32'({GrantA, GrantB}), 32'({e_ga, e_gb}));
    chk("initdone", 32'(InitDone), 32'(e_done));
  endtask

  // one clock: drive at negedge, check ready, advance model at posedge, check outputs
  task automatic step(input logic va, input logic [4:0] aa, input logic [31:0] da,
                      input logic vb, input logic [4:0] ab, input logic [31:0] db);
    bit ga, gb, ra, rb;
    hold_t h;
    ReqValidA = va; ReqAddrA = aa; ReqDataA = da;
    ReqValidB = vb; ReqAddrB = ab; ReqDataB = db;
    ga = m_run && hq_a.size() > 0 && (hq_b.size() == 0 || !m_ptr);
    gb = m_run && hq_b.size() > 0 && (hq_a.size() == 0 || m_ptr);
    ra = m_run && (hq_a.size() == 0 || ga);
    rb = m_run && (hq_b.size() == 0 || gb);
    #1;
    chk("ready_a", 32'(ReqReadyA), 32'(ra));
    chk("ready_b", 32'(ReqReadyB), 32'(rb));
    @(posedge Clk);
    if (!m_run) begin
      e_rw = 1'b1; e_wr = 5'(m_cnt); e_wd = 32'd0; e_ga = 1'b0; e_gb = 1'b0;
      exp_rf[m_cnt] = 32'd0;
      if (m_cnt == NR - 1) begin m_run = 1'b1; e_done = 1'b1; end
      m_cnt++;
    end else begin
      if (hq_a.size() > 0 && hq_b.size() > 0) m_ptr = ga;
      if (ga) begin h = hq_a.pop_front(); issue(h, 1'b1); end
      else if (gb) begin h = hq_b.pop_front(); issue(h, 1'b0); end
      else begin e_rw = 1'b0; e_ga = 1'b0; e_gb = 1'b0; end
      if (va && ra) hq_a.push_back('{aa, da});
      if (vb && rb) hq_b.push_back('{ab, db});
    end
    #1;
    chk_outputs();
    @(negedge Clk);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  typedef struct {
    logic va; logic [4:0] aa; logic [31:0] da;
    logic vb; logic [4:0] ab; logic [31:0] db;
    logic ra; logic rb;
    logic rw; logic [4:0] wr; logic [31:0] wd; logic ga; logic gb; logic cd;
  } vec_t;
  vec_t vecs[16];

  initial begin
    // inputs | ready before edge | outputs after edge (cd=0: skip address/data)
    vecs[0]  = '{1'b1,5'd2,32'd42,    1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b0,5'd31,32'd0,  1'b0,1'b0,1'b1};
    vecs[1]  = '{1'b0,5'd0,32'd0,     1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b1,5'd2,32'd42,  1'b1,1'b0,1'b1};
    vecs[2]  = '{1'b1,5'd5,32'd15,    1'b1,5'd6,32'd150,  1'b1,1'b1, 1'b0,5'd2,32'd42,  1'b0,1'b0,1'b1};
    vecs[3]  = '{1'b0,5'd0,32'd0,     1'b0,5'd0,32'd0,    1'b1,1'b0, 1'b1,5'd5,32'd15,  1'b1,1'b0,1'b1};
    vecs[4]  = '{1'b0,5'd0,32'd0,     1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b1,5'd6,32'd150, 1'b0,1'b1,1'b1};
    vecs[5]  = '{1'b1,5'd5,32'd15,    1'b1,5'd6,32'd150,  1'b1,1'b1, 1'b0,5'd6,32'd150, 1'b0,1'b0,1'b1};
    vecs[6]  = '{1'b0,5'd0,32'd0,     1'b0,5'd0,32'd0,    1'b0,1'b1, 1'b1,5'd6,32'd150, 1'b0,1'b1,1'b1};
    vecs[7]  = '{1'b0,5'd0,32'd0,     1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b1,5'd5,32'd15,  1'b1,1'b0,1'b1};
    vecs[8]  = '{1'b1,5'd8,32'd8,     1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b0,5'd5,32'd15,  1'b0,1'b0,1'b1};
    vecs[9]  = '{1'b1,5'd9,32'd9,     1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b1,5'd8,32'd8,   1'b1,1'b0,1'b1};
    vecs[10] = '{1'b1,5'd10,32'd10,   1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b1,5'd9,32'd9,   1'b1,1'b0,1'b1};
    vecs[11] = '{1'b1,5'd11,32'd11,   1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b1,5'd10,32'd10, 1'b1,1'b0,1'b1};
    vecs[12] = '{1'b0,5'd0,32'd0,     1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b1,5'd11,32'd11, 1'b1,1'b0,1'b1};
    vecs[13] = '{1'b0,5'd0,32'd0,     1'b1,5'd0,32'd1234, 1'b1,1'b1, 1'b0,5'd11,32'd11, 1'b0,1'b0,1'b1};
    vecs[14] = '{1'b0,5'd0,32'd0,     1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b0,5'd0,32'd0,   1'b0,1'b1,1'b0};
    vecs[15] = '{1'b0,5'd0,32'd0,     1'b0,5'd0,32'd0,    1'b1,1'b1, 1'b0,5'd0,32'd0,   1'b0,1'b0,1'b0};

    for (int i = 0; i < NR; i++) begin
      rf[i]     = (i == 0) ? 32'd0 : 32'hA5A5A5A5;
      exp_rf[i] = rf[i];
    end
    Reset_n = 1'b0;
    ReqValidA = 1'b0; ReqAddrA = 5'd0; ReqDataA = 32'd0;
    ReqValidB = 1'b0; ReqAddrB = 5'd0; ReqDataB = 32'd0;
    model_reset();
    repeat (2) @(negedge Clk);
    chk_outputs();
    chk("reset_ready", 32'({ReqReadyA, ReqReadyB}), 32'd0);
    Reset_n = 1'b1;

    // scrub with requesters knocking; they must not be accepted
    for (int i = 1; i < NR; i++) begin
      step(1'($urandom_range(0, 1)), 5'd3, 32'hBAD0_0001, 1'($urandom_range(0, 1)), 5'd4, 32'hBAD0_0002);
      chk("scrub_addr", 32'(WriteRegister), 32'(i));
      chk("scrub_done", 32'(InitDone), 32'(i == NR - 1));
    end

    for (int v = 0; v < 16; v++) begin
      ReqValidA = vecs[v].va; ReqAddrA = vecs[v].aa; ReqDataA = vecs[v].da;
      ReqValidB = vecs[v].vb; ReqAddrB = vecs[v].ab; ReqDataB = vecs[v].db;
      #1;
      chk($sformatf("vec%0d_ready", v), 32'({ReqReadyA, ReqReadyB}), 32'({vecs[v].ra, vecs[v].rb}));
      step(vecs[v].va, vecs[v].aa, vecs[v].da, vecs[v].vb, vecs[v].ab, vecs[v].db);
      chk($sformatf("vec%0d_we_grant", v), 32'({RegWrite, GrantA, GrantB}),
          32'({vecs[v].rw, vecs[v].ga, vecs[v].gb}));
      if (vecs[v].cd)
        chk($sformatf("vec%0d_addr_data", v), {WriteRegister, WriteData[26:0]},
            {vecs[v].wr, vecs[v].wd[26:0]});
    end
    chk("rf_r2", rf[2], 32'd42);
    chk("rf_r5", rf[5], 32'd15);
    chk("rf_r6", rf[6], 32'd150);
    chk("rf_r11", rf[11], 32'd11);
    chk("rf_r0", rf[0], 32'd0);

    // fill both holds with one write in flight, then reset mid-cycle
    step(1'b1, 5'd3, 32'h5A5A0003, 1'b1, 5'd4, 32'h5A5A0004);
    step(1'b1, 5'd7, 32'h5A5A0007, 1'b1, 5'd12, 32'h5A5A000C);
    chk("pre_reset_we", 32'(RegWrite), 32'd1);
    #2 Reset_n = 1'b0;
    watch = 1'b1;
    model_reset();
    #1;
    chk_outputs();
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 1; i < NR; i++) begin
      idle();
      if (i == 1) chk("rescrub_first", 32'({RegWrite, WriteRegister}), 32'({1'b1, 5'd1}));
    end
    repeat (4) idle();
    chk("no_stale_write", 32'(stale_cnt), 32'd0);
    watch = 1'b0;

    // random traffic, biased towards contention and same-address collisions
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
    end
    repeat (3) idle();
    for (int i = 0; i < NR; i++) chk($sformatf("rf_final_r%0d", i), rf[i], exp_rf[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
